// File: rtl/vect_serializer.sv
// vect_serializer: splits each V-element vector into ceil(V/P) beats of P elements, element 0 first.
// Optional build macro VECT_SER_LANE_MASK_EN adds the lane_mask output (real-element flag per lane).

module vect_serializer_lane #(
  parameter int V   = 4,
  parameter int P   = 2,
  parameter int BIT = 32,
  parameter int J   = 0,
  parameter int IW  = 1
) (
  input  logic [V-1:0][BIT-1:0] buffer,
  input  logic [IW-1:0]         idx,
  output logic [BIT-1:0]        elem,
  output logic                  real_elem
);
  logic [31:0] pos;

  // Element select by compare-loop keeps index widths exact for any V.
  always_comb begin
    pos       = 32'(idx) * 32'(P) + 32'(J);
    real_elem = (pos < 32'(V));
    elem      = '0;
    for (int k = 0; k < V; k++)
      if (pos == 32'(k)) elem = buffer[k];
  end
endmodule

module vect_serializer #(
  parameter int V   = 4,
  parameter int P   = 2,
  parameter int BIT = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [V-1:0][BIT-1:0] vector,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [P-1:0][BIT-1:0] outvals,
  output logic                  out_last,
  output logic                  done
`ifdef VECT_SER_LANE_MASK_EN
  ,
  output logic [P-1:0]          lane_mask
`endif
);
  localparam int NB = (V + P - 1) / P;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q;
  logic [V-1:0][BIT-1:0] buf_q;
  logic                  done_q;
  logic                  accept, fire, fire_last;
  logic [P-1:0]          lane_real;
  logic [P-1:0][BIT-1:0] lane_elem;

  assign fire      = out_valid & out_ready;
  assign fire_last = fire & out_last;
  assign accept    = in_valid & in_ready;

  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SEND;
      SEND:    if (fire_last && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // in_ready built from state directly so it does not loop through out_last.
  always_comb begin
    out_valid = (state_q == SEND);
    out_last  = (state_q == SEND) && (idx_q == LAST_IDX);
    in_ready  = (state_q == IDLE) ||
                ((state_q == SEND) && out_ready && (idx_q == LAST_IDX));
    done      = done_q;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      idx_q  <= '0;
      buf_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= fire_last;
      if (accept) begin
        buf_q <= vector;
        idx_q <= '0;
      end else if (fire && !out_last) begin
        idx_q <= idx_q + IW'(1);
      end
    end

  for (genvar j = 0; j < P; j++) begin : g_lane
    vect_serializer_lane #(.V(V), .P(P), .BIT(BIT), .J(j), .IW(IW)) u_lane (
      .buffer    (buf_q),
      .idx       (idx_q),
      .elem      (lane_elem[j]),
      .real_elem (lane_real[j])
    );
    assign outvals[j] = lane_real[j] ? lane_elem[j] : '0;
  end

`ifdef VECT_SER_LANE_MASK_EN
  assign lane_mask = out_valid ? lane_real : '0;
`endif
endmodule

// File: tb/tb_vect_serializer.sv
// Directed + randomized bench for vect_serializer: three instances (4/2, 5/2, 3/3) checked
// against a beat model computed from element positions.

module tb_vect_serializer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic iv4, ir4, ov4, or4, ol4, dn4;
  logic [3:0][31:0] vec4;
  logic [1:0][31:0] vals4;
  logic iv5, ir5, ov5, or5, ol5, dn5;
  logic [4:0][31:0] vec5;
  logic [1:0][31:0] vals5;
  logic iv3, ir3, ov3, or3, ol3, dn3;
  logic [2:0][31:0] vec3;
  logic [2:0][31:0] vals3;
`ifdef VECT_SER_LANE_MASK_EN
  logic [1:0] lm4, lm5;
  logic [2:0] lm3;
`endif

  vect_serializer #(.V(4), .P(2), .BIT(32)) dut4 (
    .clk(clk), .reset(reset), .in_valid(iv4), .in_ready(ir4), .vector(vec4),
    .out_valid(ov4), .out_ready(or4), .outvals(vals4), .out_last(ol4), .done(dn4)
`ifdef VECT_SER_LANE_MASK_EN
    , .lane_mask(lm4)
`endif
  );

  vect_serializer #(.V(5), .P(2), .BIT(32)) dut5 (
    .clk(clk), .reset(reset), .in_valid(iv5), .in_ready(ir5), .vector(vec5),
    .out_valid(ov5), .out_ready(or5), .outvals(vals5), .out_last(ol5), .done(dn5)
`ifdef VECT_SER_LANE_MASK_EN
    , .lane_mask(lm5)
`endif
  );

  vect_serializer #(.V(3), .P(3), .BIT(32)) dut3 (
    .clk(clk), .reset(reset), .in_valid(iv3), .in_ready(ir3), .vector(vec3),
    .out_valid(ov3), .out_ready(or3), .outvals(vals3), .out_last(ol3), .done(dn3)
`ifdef VECT_SER_LANE_MASK_EN
    , .lane_mask(lm3)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Beat b, lane j carries element b*p+j, or zero past the end of the vector.
  function automatic logic [31:0] lane_exp(input logic [7:0][31:0] v, input int nv,
                                           input int p, input int b, input int j);
    int k;
    k = b * p + j;
    return (k < nv) ? v[k[2:0]] : 32'h0;
  endfunction

  function automatic logic [63:0] beat2(input logic [7:0][31:0] v, input int nv, input int b);
    return {lane_exp(v, nv, 2, b, 1), lane_exp(v, nv, 2, b, 0)};
  endfunction

  function automatic logic [3:0] mexp(input int nv, input int p, input int b);
    logic [3:0] m;
    m = '0;
    for (int j = 0; j < p; j++) m[j] = (b * p + j < nv);
    return m;
  endfunction

  function automatic logic [7:0][31:0] rvec();
    logic [7:0][31:0] t;
    for (int i = 0; i < 8; i++) t[i] = $urandom;
    return t;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [7:0][31:0] va, vb;
    int b, cyc, r;
    reset = 1'b1;
    iv4 = 0; iv5 = 0; iv3 = 0; or4 = 0; or5 = 0; or3 = 0;
    vec4 = '0; vec5 = '0; vec3 = '0;
    #1;
    chk("rst_ov4", 128'(ov4), 128'(0));
    chk("rst_vals4", 128'(vals4), 128'(0));
    chk("rst_last4", 128'(ol4), 128'(0));
    chk("rst_done4", 128'(dn4), 128'(0));
    chk("rst_ov3", 128'(ov3), 128'(0));
    tick(); tick();
    reset = 1'b0;
    chk("post_rst_ir4", 128'(ir4), 128'(1));

    // basic transfer
    va = '0; va[0] = 32'h1; va[1] = 32'h2; va[2] = 32'h3; va[3] = 32'h4;
    or4 = 1; iv4 = 1; vec4 = va[3:0]; tick(); iv4 = 0;
    chk("basic_b0", 128'(vals4), 128'(64'h00000002_00000001));
    chk("basic_ov0", 128'(ov4), 128'(1));
    chk("basic_last0", 128'(ol4), 128'(0));
    chk("basic_ir0", 128'(ir4), 128'(0));
    tick();
    chk("basic_b1", 128'(vals4), 128'(64'h00000004_00000003));
    chk("basic_last1", 128'(ol4), 128'(1));
    chk("basic_ir1", 128'(ir4), 128'(1));
    tick();
    chk("basic_done", 128'(dn4), 128'(1));
    chk("basic_idle", 128'(ov4), 128'(0));
    tick();
    chk("basic_done_off", 128'(dn4), 128'(0));

    // backpressure on the first beat
    va = rvec(); or4 = 0; iv4 = 1; vec4 = va[3:0]; tick(); iv4 = 0;
    for (int c = 0; c < 3; c++) begin
      chk("bp_hold_vals", 128'(vals4), 128'(beat2(va, 4, 0)));
      chk("bp_hold_last", 128'(ol4), 128'(0));
      chk("bp_hold_ov", 128'(ov4), 128'(1));
      tick();
    end
    or4 = 1;
    chk("bp_rel_vals", 128'(vals4), 128'(beat2(va, 4, 0)));
    tick();
    chk("bp_b1_vals", 128'(vals4), 128'(beat2(va, 4, 1)));
    chk("bp_b1_last", 128'(ol4), 128'(1));
    tick();
    chk("bp_done", 128'(dn4), 128'(1));

    // random vectors under random backpressure
    for (int n = 0; n < 8; n++) begin
      va = rvec(); iv4 = 1; vec4 = va[3:0]; tick(); iv4 = 0;
      b = 0; cyc = 0;
      while (b < 2 && cyc < 40) begin
        chk("rnd_vals", 128'(vals4), 128'(beat2(va, 4, b)));
        chk("rnd_last", 128'(ol4), 128'(b == 1));
        r = (cyc > 20) ? 1 : int'($urandom_range(0, 1));
        or4 = r[0];
        tick();
        cyc++;
        if (r == 1) b++;
      end
      chk("rnd_timeout", 128'(b), 128'(2));
      chk("rnd_done", 128'(dn4), 128'(1));
    end

    // back-to-back vectors, in_valid held; second vector waits for the final handshake
    va = rvec(); vb = rvec(); or4 = 1; iv4 = 1; vec4 = va[3:0]; tick();
    vec4 = vb[3:0];
    chk("b2b_a0", 128'(vals4), 128'(beat2(va, 4, 0)));
    chk("b2b_ir_busy", 128'(ir4), 128'(0));
    tick();
    chk("b2b_a1", 128'(vals4), 128'(beat2(va, 4, 1)));
    chk("b2b_a1_last", 128'(ol4), 128'(1));
    chk("b2b_ir_last", 128'(ir4), 128'(1));
    tick(); iv4 = 0;
    chk("b2b_b0", 128'(vals4), 128'(beat2(vb, 4, 0)));
    chk("b2b_ov_cont", 128'(ov4), 128'(1));
    chk("b2b_done_a", 128'(dn4), 128'(1));
    tick();
    chk("b2b_b1", 128'(vals4), 128'(beat2(vb, 4, 1)));
    chk("b2b_done_gap", 128'(dn4), 128'(0));
    tick();
    chk("b2b_done_b", 128'(dn4), 128'(1));
    chk("b2b_idle", 128'(ov4), 128'(0));
    tick();
    chk("b2b_done_off", 128'(dn4), 128'(0));

    // padding: V=5, P=2
    va = rvec(); or5 = 1; iv5 = 1; vec5 = va[4:0]; tick(); iv5 = 0;
    for (int bb = 0; bb < 3; bb++) begin
      chk("pad_vals", 128'(vals5), 128'(beat2(va, 5, bb)));
      chk("pad_last", 128'(ol5), 128'(bb == 2));
`ifdef VECT_SER_LANE_MASK_EN
      chk("pad_mask", 128'(lm5), 128'(mexp(5, 2, bb)));
`endif
      tick();
    end
    chk("pad_done", 128'(dn5), 128'(1));

    // V = P = 3: single beat
    va = rvec(); or3 = 1; iv3 = 1; vec3 = va[2:0]; tick(); iv3 = 0;
    chk("vp_vals", 128'(vals3), 128'({va[2], va[1], va[0]}));
    chk("vp_last", 128'(ol3), 128'(1));
    chk("vp_ov", 128'(ov3), 128'(1));
`ifdef VECT_SER_LANE_MASK_EN
    chk("vp_mask", 128'(lm3), 128'(mexp(3, 3, 0)));
`endif
    tick();
    chk("vp_done", 128'(dn3), 128'(1));
    chk("vp_idle", 128'(ov3), 128'(0));
    tick();
    chk("vp_done_off", 128'(dn3), 128'(0));

    // reset between beats of a 3-beat vector
    va = rvec(); or5 = 1; iv5 = 1; vec5 = va[4:0]; tick(); iv5 = 0;
    chk("rm_b0", 128'(vals5), 128'(beat2(va, 5, 0)));
    tick();
    chk("rm_b1", 128'(vals5), 128'(beat2(va, 5, 1)));
    #2 reset = 1'b1;
    #1;
    chk("rm_ov", 128'(ov5), 128'(0));
    chk("rm_vals", 128'(vals5), 128'(0));
    chk("rm_last", 128'(ol5), 128'(0));
    chk("rm_done", 128'(dn5), 128'(0));
    tick(); tick();
    reset = 1'b0;
    chk("rm_ir_after", 128'(ir5), 128'(1));
    chk("rm_ov_after", 128'(ov5), 128'(0));
    tick();
    chk("rm_no_done1", 128'(dn5), 128'(0));
    tick();
    chk("rm_no_done2", 128'(dn5), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
